// File: rtl/hazard_stall_ctrl.sv
// Purpose: load-use and memory-wait stall control for the 5-stage RISC-V pipeline, with a stall-cycle counter.
// Latency: outputs are combinational from state and inputs; a load-use hazard inserts exactly LOAD_LAT bubbles.
// Backpressure: a pending data-memory access freezes PC through EX/MEM, takes priority over load-use and pauses its countdown.
module hazard_stall_ctrl #(
    parameter int XLEN      = 32,
    parameter int LOAD_LAT  = 1,
    parameter int STORE_FWD = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  id_inst,
    input  logic [XLEN-1:0]  ex_inst,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic [1:0]       hazard_type,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_S     = 7'b0100011;

    // Bubbles still owed after the detection cycle, which is itself the first bubble.
    localparam logic [3:0] LAT_M1     = 4'(LOAD_LAT - 1);
    localparam bit         MULTI_LAT  = (LOAD_LAT > 1);
    localparam bit         STORE_RS2  = (STORE_FWD == 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LU_WAIT  = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       rs1_used, rs2_used, lu_hit;
    logic       mem_wait, lu_stall, countdown;

    assign id_opcode = id_inst[6:0];
    assign id_rs1    = id_inst[19:15];
    assign id_rs2    = id_inst[24:20];
    assign ex_rd     = ex_inst[11:7];

    // Instruction bits that play no part in hazard detection.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{id_inst[XLEN-1:25], id_inst[14:7], ex_inst[XLEN-1:12], ex_inst[6:0]};

    // Opcode-aware source usage and load-use match against the load's destination.
    always_comb begin
        rs1_used = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) || (id_opcode == OP_JAL));
        rs2_used = (id_opcode == OP_R) || (id_opcode == OP_B) ||
                   ((id_opcode == OP_S) && STORE_RS2);
        lu_hit   = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                   ((rs1_used && (id_rs1 == ex_rd)) || (rs2_used && (id_rs2 == ex_rd)));
    end

    // Next-state logic: memory wait first, then an outstanding countdown, then fresh detection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lu_stall  = 1'b0;
        mem_wait  = mem_req && !mem_ready;
        // A memory wait that interrupted a countdown resumes it on the ready cycle, which is
        // itself a bubble so the dependent instruction cannot slip into EX.
        countdown = (state_q == S_LU_WAIT) || ((state_q == S_MEM_WAIT) && (cnt_q != 4'd0));
        if (mem_wait) begin
            state_d = S_MEM_WAIT;
        end else if (countdown) begin
            lu_stall = 1'b1;
            if (ex_branch_taken || (cnt_q == 4'd1)) begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end else begin
                state_d = S_LU_WAIT;
                cnt_d   = cnt_q - 4'd1;
            end
        end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            // A taken branch flushes the dependent instruction, so no stall is needed.
            if (lu_hit && !ex_branch_taken) begin
                lu_stall = 1'b1;
                if (MULTI_LAT) begin
                    state_d = S_LU_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
        end
    end

    // Stage enables and hazard class; forced quiet while reset is asserted.
    always_comb begin
        pc_hold     = rst_n && (mem_wait || lu_stall);
        ifid_hold   = rst_n && (mem_wait || lu_stall);
        idex_bubble = rst_n && !mem_wait && lu_stall;
        idex_hold   = rst_n && mem_wait;
        exmem_hold  = rst_n && mem_wait;
        hazard_type = 2'b00;
        if (rst_n) begin
            if (mem_wait) begin
                hazard_type = 2'b10;
            end else if (lu_stall) begin
                hazard_type = 2'b01;
            end
        end
    end

    // Saturating count of cycles with any hold or bubble.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((mem_wait || lu_stall) && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;

    // State, countdown and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule
